// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// mem_port_arbiter_pkg
// Shared encodings, widths and helpers for the CPU/DMA memory-port arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

  localparam int WORD_SIZE   = 16;
  localparam int ARB_STATE_W = 2;

  typedef enum logic [ARB_STATE_W-1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_OWN_CPU = 1'b0,
    ARB_OWN_DMA = 1'b1
  } arb_owner_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// mem_port_arbiter_if
// Requester (CPU, DMA) and memory-side signals of the shared memory port.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int WORD = mem_port_arbiter_pkg::WORD_SIZE
);
  logic            cpu_req;
  logic            cpu_we;
  logic [WORD-1:0] cpu_addr;
  logic [WORD-1:0] cpu_wdata;
  logic            dma_req;
  logic            dma_we;
  logic [WORD-1:0] dma_addr;
  logic [WORD-1:0] dma_wdata;
  logic            cpu_gnt;
  logic            dma_gnt;
  logic            cpu_done;
  logic            dma_done;
  logic [WORD-1:0] rdata;
  logic            readM;
  logic            writeM;
  logic [WORD-1:0] address;
  logic [WORD-1:0] mem_wdata;
  logic [WORD-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_gnt, dma_gnt, cpu_done, dma_done, rdata,
    output readM, writeM, address, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_gnt, dma_gnt, cpu_done, dma_done, rdata,
    input  readM, writeM, address, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_arb_wait_counter.sv
// ============================================================================
// mem_arb_wait_counter
// Saturating count of cycles the DMA requester has been kept waiting.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arb_wait_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 8,
  parameter int CW       = clog2_min1(MAX_WAIT + 1)
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          inc,
  input  wire logic          clr,
  output logic      [CW-1:0] cnt,
  output logic               ge_max
);

  localparam logic [CW-1:0] MAX_V = CW'(MAX_WAIT);

  // Clear wins over increment: the cycle DMA is granted it stops waiting.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && (cnt < MAX_V)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign ge_max = (cnt >= MAX_V);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter
// Shares one memory port between CPU and DMA; CPU-first with a DMA starvation guard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD        = WORD_SIZE,
  parameter int MEM_LATENCY = 2,
  parameter int MAX_WAIT    = 8
) (
  input  wire logic         clk,
  input  wire logic         reset,
  mem_port_arbiter_if.slave bus
);

  localparam int              LW       = clog2_min1(MEM_LATENCY);
  localparam int              WW       = clog2_min1(MAX_WAIT + 1);
  localparam logic [LW-1:0]   LAT_INIT = LW'(MEM_LATENCY - 1);

  arb_state_t      state;
  arb_state_t      state_nxt;
  arb_owner_t      owner;
  logic            we_q;
  logic [WORD-1:0] addr_q;
  logic [WORD-1:0] wdata_q;
  logic [WORD-1:0] rdata_q;
  logic [LW-1:0]   lat_cnt;
  logic [WW-1:0]   wait_cnt;
  logic            wait_ge_max;
  logic            any_req;
  logic            dma_wins;
  logic            dma_owns;
  logic            wait_inc;
  logic            wait_clr;

  assign any_req  = bus.cpu_req | bus.dma_req;
  assign dma_wins = bus.dma_req & (wait_ge_max | ~bus.cpu_req);
  assign dma_owns = (state != ARB_IDLE) && (owner == ARB_OWN_DMA);
  assign wait_inc = bus.dma_req & ~dma_owns;
  assign wait_clr = (state == ARB_IDLE) & dma_wins;

  mem_arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT),
    .CW       (WW)
  ) u_wait (
    .clk    (clk),
    .reset  (reset),
    .inc    (wait_inc),
    .clr    (wait_clr),
    .cnt    (wait_cnt),
    .ge_max (wait_ge_max)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bus.readM    = 1'b0;
    bus.writeM   = 1'b0;
    bus.cpu_gnt  = 1'b0;
    bus.dma_gnt  = 1'b0;
    bus.cpu_done = 1'b0;
    bus.dma_done = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (any_req) state_nxt = ARB_ACCESS;
      end
      ARB_ACCESS: begin
        bus.readM   = ~we_q;
        bus.writeM  = we_q;
        bus.cpu_gnt = (owner == ARB_OWN_CPU);
        bus.dma_gnt = (owner == ARB_OWN_DMA);
        if (lat_cnt == '0) state_nxt = ARB_DONE;
      end
      ARB_DONE: begin
        bus.cpu_gnt  = (owner == ARB_OWN_CPU);
        bus.dma_gnt  = (owner == ARB_OWN_DMA);
        bus.cpu_done = (owner == ARB_OWN_CPU);
        bus.dma_done = (owner == ARB_OWN_DMA);
        state_nxt    = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Payload is captured only at arbitration so requesters may change it mid-access.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner   <= ARB_OWN_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      lat_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            owner   <= dma_wins ? ARB_OWN_DMA : ARB_OWN_CPU;
            we_q    <= dma_wins ? bus.dma_we    : bus.cpu_we;
            addr_q  <= dma_wins ? bus.dma_addr  : bus.cpu_addr;
            wdata_q <= dma_wins ? bus.dma_wdata : bus.cpu_wdata;
            lat_cnt <= LAT_INIT;
          end
        end
        ARB_ACCESS: begin
          if (lat_cnt == '0) begin
            if (!we_q) rdata_q <= bus.mem_rdata;
          end else begin
            lat_cnt <= lat_cnt - LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.address   = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rdata     = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter
// Directed self-checking bench for the CPU/DMA memory-port arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  mem_port_arbiter_if #(.WORD(16)) bus ();

  mem_port_arbiter #(
    .WORD        (16),
    .MEM_LATENCY (2),
    .MAX_WAIT    (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Each call lands 1 time unit after a rising edge, i.e. at the start of a cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_req   = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req   = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    bus.mem_rdata = '0;
  endtask

  function automatic logic in_rng(input int k, input int lo, input int hi);
    return (k >= lo) && (k <= hi);
  endfunction

  initial begin
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    check("rst_state",  32'(dut.state), 32'(ARB_IDLE));
    check("rst_strobe", {bus.readM, bus.writeM}, 0);
    check("rst_gnt",    {bus.cpu_gnt, bus.dma_gnt, bus.cpu_done, bus.dma_done}, 0);
    check("rst_addr",   bus.address, 0);
    check("rst_wdata",  bus.mem_wdata, 0);
    check("rst_rdata",  bus.rdata, 0);
    check("rst_wait",   32'(dut.wait_cnt), 0);
    reset = 1'b0;
    next_cycle();

    // CPU read of 0x0010
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010; bus.mem_rdata = 16'hBEEF;
    check("t1_c0_readM", bus.readM, 0);
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      if (k == 3) bus.cpu_req = 1'b0;
      check($sformatf("t1_c%0d_readM", k), bus.readM, 32'(in_rng(k, 1, 2)));
      check($sformatf("t1_c%0d_cgnt", k), bus.cpu_gnt, 32'(in_rng(k, 1, 3)));
      check($sformatf("t1_c%0d_cdone", k), bus.cpu_done, 32'(k == 3));
      check($sformatf("t1_c%0d_dma", k), {bus.dma_gnt, bus.dma_done}, 0);
      if (in_rng(k, 1, 2)) check($sformatf("t1_c%0d_addr", k), bus.address, 16'h0010);
      if (k == 3) check("t1_rdata", bus.rdata, 16'hBEEF);
    end

    // DMA write of 0x1234 to 0x0200; rdata must keep 0xBEEF
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 16'h0200; bus.dma_wdata = 16'h1234;
    bus.mem_rdata = 16'h5555;
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      if (k == 1) bus.dma_wdata = 16'hFFFF;
      if (k == 3) bus.dma_req = 1'b0;
      check($sformatf("t2_c%0d_writeM", k), bus.writeM, 32'(in_rng(k, 1, 2)));
      check($sformatf("t2_c%0d_readM", k), bus.readM, 0);
      check($sformatf("t2_c%0d_dgnt", k), bus.dma_gnt, 32'(in_rng(k, 1, 3)));
      check($sformatf("t2_c%0d_ddone", k), bus.dma_done, 32'(k == 3));
      check($sformatf("t2_c%0d_cpu", k), {bus.cpu_gnt, bus.cpu_done}, 0);
      if (in_rng(k, 1, 2)) begin
        check($sformatf("t2_c%0d_wdata", k), bus.mem_wdata, 16'h1234);
        check($sformatf("t2_c%0d_addr", k), bus.address, 16'h0200);
      end
      check($sformatf("t2_c%0d_rdata", k), bus.rdata, 16'hBEEF);
    end

    // Simultaneous single requests: CPU first, then DMA
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0030;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0040;
    bus.mem_rdata = 16'hA5A5;
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
      if (k == 3) bus.cpu_req = 1'b0;
      if (k == 7) bus.dma_req = 1'b0;
      if (k == 5) bus.mem_rdata = 16'h3C3C;
      check($sformatf("t3_c%0d_cgnt", k), bus.cpu_gnt, 32'(in_rng(k, 1, 3)));
      check($sformatf("t3_c%0d_dgnt", k), bus.dma_gnt, 32'(in_rng(k, 5, 7)));
      check($sformatf("t3_c%0d_cdone", k), bus.cpu_done, 32'(k == 3));
      check($sformatf("t3_c%0d_ddone", k), bus.dma_done, 32'(k == 7));
      if (k == 4) check("t3_wait_c4", 32'(dut.wait_cnt), 4);
      if (k == 5) check("t3_addr_c5", bus.address, 16'h0040);
      if (k == 7) check("t3_rdata_c7", bus.rdata, 16'h3C3C);
    end

    // Starvation guard: CPU holds req, DMA waits MAX_WAIT cycles then wins
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0011;
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 16'h0022; bus.dma_wdata = 16'h00AB;
    for (int k = 1; k <= 15; k++) begin
      next_cycle();
      if (k == 11) bus.dma_req = 1'b0;
      if (k == 15) bus.cpu_req = 1'b0;
      check($sformatf("t4_c%0d_cgnt", k), bus.cpu_gnt,
            32'(in_rng(k, 1, 3) || in_rng(k, 5, 7) || in_rng(k, 13, 15)));
      check($sformatf("t4_c%0d_dgnt", k), bus.dma_gnt, 32'(in_rng(k, 9, 11)));
      check($sformatf("t4_c%0d_ddone", k), bus.dma_done, 32'(k == 11));
      check($sformatf("t4_c%0d_cdone", k), bus.cpu_done, 32'(k == 3 || k == 7 || k == 15));
      if (k == 4) check("t4_wait_c4", 32'(dut.wait_cnt), 4);
      if (k == 8) check("t4_wait_c8", 32'(dut.wait_cnt), 8);
      if (k == 9) check("t4_wait_c9", 32'(dut.wait_cnt), 0);
      if (k == 9) check("t4_wdata_c9", bus.mem_wdata, 16'h00AB);
    end
    next_cycle();

    // Reset during the second ACCESS cycle of a CPU read
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0055; bus.mem_rdata = 16'h1111;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0066;
    next_cycle();
    next_cycle();
    check("t5_c2_readM", bus.readM, 1);
    check("t5_c2_wait", 32'(dut.wait_cnt), 2);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    bus.mem_rdata = 16'h7777;
    check("t5_c3_readM", bus.readM, 0);
    check("t5_c3_cdone", bus.cpu_done, 0);
    check("t5_c3_cgnt", bus.cpu_gnt, 0);
    check("t5_c3_state", 32'(dut.state), 32'(ARB_IDLE));
    check("t5_c3_wait", 32'(dut.wait_cnt), 0);
    check("t5_c3_rdata", bus.rdata, 0);
    for (int k = 4; k <= 10; k++) begin
      next_cycle();
      if (k == 6) bus.cpu_req = 1'b0;
      if (k == 10) bus.dma_req = 1'b0;
      check($sformatf("t5_c%0d_readM", k), bus.readM, 32'(in_rng(k, 4, 5) || in_rng(k, 8, 9)));
      check($sformatf("t5_c%0d_cdone", k), bus.cpu_done, 32'(k == 6));
      check($sformatf("t5_c%0d_ddone", k), bus.dma_done, 32'(k == 10));
      check($sformatf("t5_c%0d_onegnt", k), 32'(bus.cpu_gnt & bus.dma_gnt), 0);
      if (k == 6) check("t5_rdata_c6", bus.rdata, 16'h7777);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
